// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key codes and helpers for the keypad scanner.
// Provides the FSM state enum, the [row][col] keymap and row priority pick.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_EMIT     = 2'd2,
    ST_HOLD     = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_STAR  = 4'hE;
  localparam logic [3:0] KEY_HASH  = 4'hF;
  localparam logic [3:0] ROWS_IDLE = 4'hF;

  function automatic logic [3:0] keymap(
    input logic [1:0] row,
    input logic [1:0] col
  );
    logic [3:0] code;
    code = 4'h0;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
    endcase
    return code;
  endfunction

  // Lowest-numbered low row wins when several rows are pulled down.
  function automatic logic [1:0] first_low(input logic [3:0] rows);
    logic [1:0] r;
    r = 2'd3;
    for (int i = 3; i >= 0; i--) begin
      if (!rows[i]) r = i[1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// keypad_row_sync: 2-flop synchronizer for the 4 active-low keypad rows.
// Ports: clk, rst (async, high), d (raw rows), q (synced rows, reset 4'hF).
module keypad_row_sync
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d,
  output logic [3:0] q
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= ROWS_IDLE;
      sync_q <= ROWS_IDLE;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad scan, debounce, one code per press.
// Ports: clk, rst (async, high), row_in[3:0] (rows, active-low),
// col_out[3:0] (one-hot-low drive), key_val[3:0], key_valid (1-cycle pulse).
// Build option KEYPAD_REPEAT_EN: re-pulse key_valid every REPEAT_CYCLES
// while the accepted key stays held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV        = 4,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_CYCLES   = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] row_in,
  output logic [3:0] col_out,
  output logic [3:0] key_val,
  output logic       key_valid
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST = BW'(DEBOUNCE_CYCLES - 1);

  logic [3:0] rows_s;

  kp_state_e     state_q, state_d;
  logic [1:0]    col_q, col_d;
  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] deb_q, deb_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    pat_q, pat_d;
  logic [3:0]    key_val_q, key_val_d;
  logic          key_valid_q, key_valid_d;
  // Cleared by reset; set once a full column sweep finishes idle. A key
  // held across reset is therefore swallowed until released and re-pressed.
  logic          armed_q, armed_d;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
  logic [RW-1:0] rep_q, rep_d;
`else
  if (REPEAT_CYCLES < 2) begin : g_rep_unused
  end
`endif

  keypad_row_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (row_in),
    .q   (rows_s)
  );

  always_comb begin
    state_d     = state_q;
    col_d       = col_q;
    div_d       = div_q;
    deb_d       = deb_q;
    row_d       = row_q;
    pat_d       = pat_q;
    key_val_d   = key_val_q;
    key_valid_d = 1'b0;
    armed_d     = armed_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d       = rep_q;
`endif
    unique case (state_q)
      ST_SCAN: begin
        if (div_q != DIV_LAST) begin
          div_d = div_q + 1'b1;
        end else begin
          div_d = '0;
          if (rows_s != ROWS_IDLE) begin
            row_d   = first_low(rows_s);
            pat_d   = rows_s;
            deb_d   = '0;
            state_d = ST_DEBOUNCE;
          end else begin
            col_d = col_q + 2'd1;
            if (col_q == 2'd3) armed_d = 1'b1;
          end
        end
      end
      ST_DEBOUNCE: begin
        if (rows_s != pat_q) begin
          div_d   = '0;
          state_d = ST_SCAN;
        end else if (deb_q == DEB_LAST) begin
          state_d = ST_EMIT;
        end else begin
          deb_d = deb_q + 1'b1;
        end
      end
      ST_EMIT: begin
        if (armed_q) begin
          key_val_d   = keymap(row_q, col_q);
          key_valid_d = 1'b1;
        end
        deb_d   = '0;
        state_d = ST_HOLD;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = '0;
`endif
      end
      ST_HOLD: begin
        if (rows_s == ROWS_IDLE) begin
          if (deb_q == DEB_LAST) begin
            col_d   = col_q + 2'd1;
            div_d   = '0;
            state_d = ST_SCAN;
          end else begin
            deb_d = deb_q + 1'b1;
          end
        end else begin
          deb_d = '0;
        end
`ifdef KEYPAD_REPEAT_EN
        if (rows_s == pat_q) begin
          if (rep_q == REP_LAST) begin
            rep_d       = '0;
            key_valid_d = armed_q;
          end else begin
            rep_d = rep_q + 1'b1;
          end
        end else begin
          rep_d = '0;
        end
`endif
      end
      default: state_d = ST_SCAN;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      col_q       <= 2'd0;
      div_q       <= '0;
      deb_q       <= '0;
      row_q       <= 2'd0;
      pat_q       <= ROWS_IDLE;
      key_val_q   <= 4'h0;
      key_valid_q <= 1'b0;
      armed_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      div_q       <= div_d;
      deb_q       <= deb_d;
      row_q       <= row_d;
      pat_q       <= pat_d;
      key_val_q   <= key_val_d;
      key_valid_q <= key_valid_d;
      armed_q     <= armed_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q       <= rep_d;
`endif
    end
  end

  assign col_out   = ~(4'b0001 << col_q);
  assign key_val   = key_val_q;
  assign key_valid = key_valid_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model + procedural reference, checked per cycle.
// Directed scenarios pin the reference with literal key codes.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 16;
  localparam int REP      = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_val;
  logic       key_valid;

  logic [15:0] keys   = '0;
  logic [3:0]  glitch = '0;

  int checks = 0;
  int errors = 0;

  keypad_scanner #(
    .SCAN_DIV        (SCAN_DIV),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .row_in    (row_in),
    .col_out   (col_out),
    .key_val   (key_val),
    .key_valid (key_valid)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key shorts its row to the driven column.
  always_comb begin
    row_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (keys[r*4+c] && !col_out[c]) row_in[r] = 1'b0;
      end
    end
    row_in = row_in & ~glitch;
  end

  logic [3:0] kmap [16] = '{
    4'h1, 4'h2, 4'h3, 4'hA,
    4'h4, 4'h5, 4'h6, 4'hB,
    4'h7, 4'h8, 4'h9, 4'hC,
    4'hE, 4'h0, 4'hF, 4'hD
  };

  // ---------------- reference model ----------------
  logic [3:0] m_s1 = 4'hF;
  logic [3:0] m_s2 = 4'hF;
  int         exp_col = 0;
  logic [3:0] exp_val = 4'h0;
  logic       exp_valid = 1'b0;
  bit         armed = 0;
  bit         aborted = 0;

  task automatic edge_(output logic [3:0] rs);
    @(posedge clk);
    if (rst) begin
      aborted   = 1;
      m_s1      = 4'hF;
      m_s2      = 4'hF;
      exp_col   = 0;
      exp_val   = 4'h0;
      exp_valid = 1'b0;
      armed     = 0;
      rs        = 4'hF;
    end else begin
      rs        = m_s2;
      m_s2      = m_s1;
      m_s1      = row_in;
      exp_valid = 1'b0;
    end
  endtask

  task automatic run_model();
    logic [3:0] rs, pat;
    int c, r, run, mrun;
    bit ok;
    c = 0;
    forever begin
      for (int i = 0; i < SCAN_DIV; i++) begin
        edge_(rs);
        if (aborted) return;
      end
      if (rs == 4'hF) begin
        if (c == 3) armed = 1;
        c = (c + 1) % 4;
        exp_col = c;
        continue;
      end
      pat = rs;
      r = 0;
      while (pat[r]) r++;
      ok = 1;
      for (int i = 0; i < DEB; i++) begin
        edge_(rs);
        if (aborted) return;
        if (rs != pat) begin
          ok = 0;
          break;
        end
      end
      if (!ok) continue;
      edge_(rs);
      if (aborted) return;
      if (armed) begin
        exp_valid = 1'b1;
        exp_val   = kmap[r*4+c];
      end
      run  = 0;
      mrun = 0;
      while (run < DEB) begin
        edge_(rs);
        if (aborted) return;
        run = (rs == 4'hF) ? run + 1 : 0;
`ifdef KEYPAD_REPEAT_EN
        mrun = (rs == pat) ? mrun + 1 : 0;
        if (armed && mrun > 0 && mrun % REP == 0) exp_valid = 1'b1;
`endif
      end
      c = (c + 1) % 4;
      exp_col = c;
    end
  endtask

  initial begin
    forever begin
      aborted = 0;
      run_model();
    end
  end

  // ---------------- per-cycle compare ----------------
  logic       prev_valid = 1'b0;
  logic [3:0] want_col;
  logic [3:0] seen [$];

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if (col_out !== 4'b1110 || key_val !== 4'h0 || key_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_outputs col_out=%b key_val=%h key_valid=%b required 1110/0/0",
                 col_out, key_val, key_valid);
      end
    end else begin
      want_col = ~(4'b0001 << exp_col);
      checks++;
      if (col_out !== want_col) begin
        errors++;
        $display("FAIL col_out t=%0t actual=%b required=%b", $time, col_out, want_col);
      end
      checks++;
      if (key_valid !== exp_valid) begin
        errors++;
        $display("FAIL key_valid t=%0t actual=%b required=%b", $time, key_valid, exp_valid);
      end
      checks++;
      if (key_val !== exp_val) begin
        errors++;
        $display("FAIL key_val t=%0t actual=%h required=%h", $time, key_val, exp_val);
      end
      checks++;
      if (prev_valid && key_valid) begin
        errors++;
        $display("FAIL back_to_back_valid t=%0t actual=11 required=not both high", $time);
      end
      if (key_valid) seen.push_back(key_val);
    end
    prev_valid = key_valid;
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic press(input int idx, input int hold, input int gap);
    keys[idx] = 1'b1;
    cyc(hold);
    keys[idx] = 1'b0;
    cyc(gap);
  endtask

  function automatic logic [3:0] seen_at(input int i);
    return (seen.size() > i) ? seen[i] : 4'hX;
  endfunction

  initial begin
    int k, h, g, run;
    cyc(3);
    check("reset_col", col_out, 4'b1110);
    check("reset_val", key_val, 4'h0);
    check("reset_valid", key_valid, 1'b0);
    rst = 1'b0;
    cyc(30);

    // key '5' held; column must stay frozen while held
    seen.delete();
    keys[5] = 1'b1;
    cyc(60);
    check("t1_col_frozen", col_out, 4'b1101);
    keys[5] = 1'b0;
    cyc(40);
    check("t1_count", seen.size(), 1);
    check("t1_val", seen_at(0), 4'h5);

    // key '9' with three short bounces
    seen.delete();
    for (int b = 0; b < 3; b++) begin
      keys[10] = 1'b1;
      cyc(5);
      keys[10] = 1'b0;
      cyc(3);
    end
    press(10, 60, 40);
    check("t2_count", seen.size(), 1);
    check("t2_val", seen_at(0), 4'h9);

    // short glitch on row 0: no key, scanning keeps rotating
    seen.delete();
    glitch = 4'b0001;
    cyc(5);
    glitch = 4'b0000;
    cyc(8);
    k = int'(col_out);
    cyc(SCAN_DIV);
    check("t3_rotating", (int'(col_out) != k), 1);
    cyc(20);
    check("t3_count", seen.size(), 0);

    // rows 0 and 2 on column 3 together: row 0 wins
    seen.delete();
    keys[3]  = 1'b1;
    keys[11] = 1'b1;
    cyc(60);
    keys = '0;
    cyc(40);
    check("t4_count", seen.size(), 1);
    check("t4_val", seen_at(0), 4'hA);

    // reset while '7' is debouncing, key held through reset
    seen.delete();
    keys[8] = 1'b1;
    run = 0;
    for (int i = 0; i < 60 && run < SCAN_DIV + 2; i++) begin
      cyc(1);
      run = (col_out == 4'b1110) ? run + 1 : 0;
    end
    check("t5_in_debounce", run, SCAN_DIV + 2);
    rst = 1'b1;
    cyc(1);
    check("t5_rst_col", col_out, 4'b1110);
    check("t5_rst_val", key_val, 4'h0);
    check("t5_rst_valid", key_valid, 1'b0);
    cyc(2);
    rst = 1'b0;
    cyc(80);
    keys[8] = 1'b0;
    cyc(40);
    check("t5_held_count", seen.size(), 0);
    press(8, 60, 40);
    check("t5_repress_count", seen.size(), 1);
    check("t5_repress_val", seen_at(0), 4'h7);

    // 1, 2, 3, 4 in order
    seen.delete();
    press(0, 60, 40);
    press(1, 60, 40);
    press(2, 60, 40);
    press(4, 60, 40);
    check("t6_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) check("t6_seq", seen_at(i), 4'(i + 1));

`ifdef KEYPAD_REPEAT_EN
    // '0' held: repeated pulses
    seen.delete();
    press(13, 3 * REP + 60, 40);
    check("t7_repeat_count", (seen.size() >= 3), 1);
    for (int i = 0; i < 3; i++) check("t7_repeat_val", seen_at(i), 4'h0);
`endif

    // randomized presses, combos, glitches and resets
    for (int it = 0; it < 40; it++) begin
      k = $urandom_range(0, 15);
      h = $urandom_range(1, 70);
      g = $urandom_range(1, 50);
      keys = '0;
      keys[k] = 1'b1;
      if ($urandom_range(0, 3) == 0) keys[$urandom_range(0, 15)] = 1'b1;
      if ($urandom_range(0, 5) == 0) glitch = 4'($urandom_range(1, 15));
      cyc(h);
      keys = '0;
      glitch = '0;
      cyc(g);
      if ($urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
      end
    end
    cyc(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 active-low matrix keypad, debounces presses, and emits one 4-bit hex key code per press as a single-cycle `key_valid` pulse. It sits directly upstream of the password matcher and drives its `key_val`/`key_valid` inputs. One key is reported per press, and the next press must follow a debounced release.

## Interface
- `SCAN_DIV`, default 4: clocks spent on each column; minimum 3, which covers synchronizer latency plus settling.
- `DEBOUNCE_CYCLES`, default 16: consecutive stable sampled cycles required to accept a press or a release; minimum 2.
- `REPEAT_CYCLES`, default 64: auto-repeat period, used only with `KEYPAD_REPEAT_EN`.
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `row_in`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_out`  out  4  column drive, one-hot-low (exactly one bit 0).
- `key_val`  out  4  code of the accepted key; holds its value until the next accept.
- `key_valid`  out  1  one-cycle pulse; `key_val` is valid in the same cycle.

## Operation
- `row_in` passes through a 2-flop synchronizer (reset 4'hF) to give `rows_s`.
- Keymap, `[row][col]`, giving the code:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: `*`=E 0 `#`=F D
- Multiple rows low: the lowest row index wins. Other columns are never considered while a key is latched.
- FSM states:
  - **SCAN**
    - `col_out` = ~(1<<col_idx); `div_cnt` counts 0..SCAN_DIV-1.
    - At `div_cnt`==SCAN_DIV-1: if `rows_s`!=4'hF, latch col_idx, the winning row, and `rows_s` as the pattern, clear `deb_cnt`, go to DEBOUNCE.
    - Otherwise col_idx increments modulo 4 (3→0) and `div_cnt` restarts.
  - **DEBOUNCE**
    - Column frozen. Each cycle `rows_s`==pattern increments `deb_cnt`.
    - Any mismatch: return to SCAN with `div_cnt`=0 on the same column.
    - `deb_cnt`==DEBOUNCE_CYCLES-1 with a match: go to EMIT.
  - **EMIT**
    - One cycle. Register `key_val`=keymap, `key_valid`=1; go to HOLD with `deb_cnt`=0.
  - **HOLD**
    - Column frozen. Each cycle `rows_s`==4'hF increments `deb_cnt`; any low row clears it.
    - Reaching DEBOUNCE_CYCLES-1: go to SCAN on the next column.
- `key_valid` is never high on two consecutive cycles.
- Counter widths are `$clog2` of their parameter. Counters saturate and never wrap.

## Timing
- Reset values: `col_out`=4'b1110, `key_val`=4'h0, `key_valid`=0, state SCAN, col_idx 0, all counters 0, sync regs 4'hF.
- Reset mid-operation: everything returns to reset values immediately and any pending press is discarded. The key must be released and pressed again to be reported.
- Press latency, from a stable low on `row_in` in the driven column: at most 2 (sync) + SCAN_DIV + DEBOUNCE_CYCLES + 1 clocks to `key_valid`.
- Worst-case detection adds 3×SCAN_DIV for column rotation.
- Release: `key_valid` cannot reassert earlier than DEBOUNCE_CYCLES after `rows_s` returns to 4'hF.
- Outputs are registered, with no combinational path from `row_in`.

## Configuration
- `KEYPAD_REPEAT_EN` defined:
  - In HOLD, a separate counter runs while the latched pattern stays matched.
  - Every REPEAT_CYCLES clocks it re-pulses `key_valid` with the same `key_val`.
  - The counter clears on any mismatch.
- `KEYPAD_REPEAT_EN` undefined: the repeat counter is absent, `REPEAT_CYCLES` is unused, and exactly one pulse is emitted per press.

## Structure
- Package `keypad_pkg` contains:
  - FSM state enum (SCAN, DEBOUNCE, EMIT, HOLD).
  - Key code constants (KEY_STAR=4'hE, KEY_HASH=4'hF).
  - Keymap function taking (row, col) and returning a 4-bit code.
- Sub-module `keypad_row_sync`: 2-flop, 4-bit synchronizer with reset value 4'hF.

## Test plan
- Hold row 1 low whenever col 1 is driven, for 40 cycles → exactly one `key_valid` with `key_val`=4'h5; `col_out` frozen at 4'b1101 until release.
- Press '9' with 3 bounce glitches shorter than DEBOUNCE_CYCLES, then stable → exactly one pulse, 4'h9.
- Glitch row 0 low for 5 cycles only → no `key_valid`; scanning resumes with the column rotating.
- Rows 0 and 2 low together on col 3 → `key_val`=4'hA.
- Assert `rst` during DEBOUNCE of '7' → outputs at reset values, no pulse; key held through reset → no pulse until released and pressed again.
- Press 1, 2, 3, 4 sequentially with releases, connected to the password matcher → four pulses 4'h1..4'h4 in order.
- With `KEYPAD_REPEAT_EN`, hold '0' for 3×REPEAT_CYCLES → repeated 4'h0 pulses, spaced REPEAT_CYCLES apart.
